// File: rtl/clk_en_pkg.sv
// Shared constants, divisor type and effective-divisor helper for the clk_en_gen clock-enable generator.
package clk_en_pkg;

   localparam int NUM_CH_DEFAULT = 4;
   localparam int DIV_W_DEFAULT  = 24;

   typedef logic [DIV_W_DEFAULT-1:0] div_t;

   // A divisor of 0 behaves like 1: a tick on every enabled cycle.
   function automatic div_t eff_div(input div_t d);
      return (d == '0) ? div_t'(1) : d;
   endfunction

endpackage

// File: rtl/clk_en_channel.sv
// One divider channel: counter, programmable divisor, registered tick pulse and 50% square output.
module clk_en_channel
   import clk_en_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEFAULT,
   parameter int DEFAULT_DIV = 100000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clr,
   input  logic             load,
   input  logic [DIV_W-1:0] load_div,
   output logic             tick,
   output logic             square
);

   logic [DIV_W-1:0] count_reg;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] neff_m1;
   logic             tick_reg;
   logic             square_reg;
   logic             terminal;

   // DIV_W is expected not to exceed DIV_W_DEFAULT, the width of the helper type.
   assign neff_m1  = DIV_W'(eff_div(div_t'(div_reg)) - div_t'(1));
   assign terminal = (count_reg == neff_m1);

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg  <= '0;
         div_reg    <= DIV_W'(DEFAULT_DIV);
         tick_reg   <= 1'b0;
         square_reg <= 1'b0;
      end else begin
         if (load) begin
            div_reg <= load_div;
         end
         // Phase clear beats a divisor load, which beats the terminal count.
         if (clr) begin
            count_reg  <= '0;
            tick_reg   <= 1'b0;
            square_reg <= 1'b0;
         end else if (load) begin
            count_reg <= '0;
            tick_reg  <= 1'b0;
         end else if (enable) begin
            if (terminal) begin
               count_reg  <= '0;
               tick_reg   <= 1'b1;
               square_reg <= ~square_reg;
            end else begin
               count_reg <= count_reg + 1'b1;
               tick_reg  <= 1'b0;
            end
         end else begin
            tick_reg <= 1'b0;
         end
      end
   end

   assign tick   = tick_reg;
   assign square = square_reg;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel synchronous clock-enable generator with a valid/ready divisor-update port.
// Optional phase-align input sync_clr is present when CLK_EN_GEN_SYNC_CLR_EN is defined.
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter  int NUM_CH      = NUM_CH_DEFAULT,
   parameter  int DIV_W       = DIV_W_DEFAULT,
   parameter  int DEFAULT_DIV = 100000,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
`ifdef CLK_EN_GEN_SYNC_CLR_EN
   input  logic              sync_clr,
`endif
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] square
);

   logic              accept;
   logic              ch_in_range;
   logic              clr;
   logic              cfg_ready_reg;
   logic              cfg_err_reg;
   logic [NUM_CH-1:0] load_vec;

`ifdef CLK_EN_GEN_SYNC_CLR_EN
   assign clr = sync_clr;
`else
   assign clr = 1'b0;
`endif

   assign accept      = cfg_valid & cfg_ready_reg;
   assign ch_in_range = ({1'b0, cfg_ch} < (CH_W+1)'(NUM_CH));

   // Ready drops for one cycle after every accepted update, capping the rate at one per two cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         cfg_ready_reg <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         cfg_ready_reg <= ~accept;
         if (accept && !ch_in_range) begin
            cfg_err_reg <= 1'b1;
         end
      end
   end

   assign cfg_ready = cfg_ready_reg;
   assign cfg_err   = cfg_err_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign load_vec[gi] = accept && (cfg_ch == CH_W'(gi));

         clk_en_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_channel (
            .clock    (clock),
            .reset    (reset),
            .enable   (enable),
            .clr      (clr),
            .load     (load_vec[gi]),
            .load_div (cfg_div),
            .tick     (tick[gi]),
            .square   (square[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen (NUM_CH=2, DIV_W=8, DEFAULT_DIV=4) plus a NUM_CH=3 instance for cfg_err.
module tb_clk_en_gen;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       cfg_valid;
   logic       cfg_ready;
   logic       cfg_ch;
   logic [7:0] cfg_div;
   logic       cfg_err;
   logic [1:0] tick;
   logic [1:0] square;
`ifdef CLK_EN_GEN_SYNC_CLR_EN
   logic       sync_clr;
`endif

   logic       e_valid;
   logic       e_ready;
   logic [1:0] e_ch;
   logic [7:0] e_div;
   logic       e_err;
   logic [2:0] e_tick;
   logic [2:0] e_square;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   clk_en_gen #(.NUM_CH(2), .DIV_W(8), .DEFAULT_DIV(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
`ifdef CLK_EN_GEN_SYNC_CLR_EN
      .sync_clr  (sync_clr),
`endif
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .square    (square)
   );

   clk_en_gen #(.NUM_CH(3), .DIV_W(8), .DEFAULT_DIV(4)) dut_err (
      .clock     (clock),
      .reset     (reset),
      .enable    (1'b1),
`ifdef CLK_EN_GEN_SYNC_CLR_EN
      .sync_clr  (1'b0),
`endif
      .cfg_valid (e_valid),
      .cfg_ready (e_ready),
      .cfg_ch    (e_ch),
      .cfg_div   (e_div),
      .cfg_err   (e_err),
      .tick      (e_tick),
      .square    (e_square)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, sample 1 ns later and compare tick, square and cfg_ready.
   task automatic cyc(input string tag, input logic [1:0] et, input logic [1:0] es, input logic er);
      @(posedge clock);
      #1;
      $display("cycle %s tick=%b square=%b ready=%b err=%b", tag, tick, square, cfg_ready, cfg_err);
      chk({tag, "_tick"},   {6'd0, tick},   {6'd0, et});
      chk({tag, "_square"}, {6'd0, square}, {6'd0, es});
      chk({tag, "_ready"},  {7'd0, cfg_ready}, {7'd0, er});
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_ch    = 1'b0;
      cfg_div   = 8'd0;
      e_valid   = 1'b0;
      e_ch      = 2'd0;
      e_div     = 8'd0;
`ifdef CLK_EN_GEN_SYNC_CLR_EN
      sync_clr  = 1'b0;
`endif
      repeat (3) @(posedge clock);
      #1;
      $display("reset state tick=%b square=%b ready=%b err=%b", tick, square, cfg_ready, cfg_err);
      chk("rst_tick",   {6'd0, tick},   8'd0);
      chk("rst_square", {6'd0, square}, 8'd0);
      chk("rst_ready",  {7'd0, cfg_ready}, 8'd0);
      chk("rst_err",    {7'd0, cfg_err},   8'd0);
      chk("rst_e_err",  {7'd0, e_err},     8'd0);

      // Free run from reset release at DEFAULT_DIV=4; out-of-range update on the 3-channel instance.
      reset  = 1'b0;
      enable = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         cyc($sformatf("run%0d", n), (n % 4 == 0) ? 2'b11 : 2'b00,
             ((n / 4) % 2 == 1) ? 2'b11 : 2'b00, 1'b1);
         chk($sformatf("e_err%0d", n),   {7'd0, e_err},   (n >= 6) ? 8'd1 : 8'd0);
         chk($sformatf("e_ready%0d", n), {7'd0, e_ready}, (n == 6) ? 8'd0 : 8'd1);
         chk($sformatf("e_tick%0d", n),  {5'd0, e_tick},  (n % 4 == 0) ? 8'd7 : 8'd0);
         chk($sformatf("e_sq%0d", n),    {5'd0, e_square}, ((n / 4) % 2 == 1) ? 8'd7 : 8'd0);
         if (n == 5) begin
            e_valid = 1'b1;
            e_ch    = 2'd3;
            e_div   = 8'd1;
         end
         if (n == 6) e_valid = 1'b0;
      end

      // ch1 <- 3
      cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3;
      cyc("c13", 2'b00, 2'b11, 1'b0);
      cfg_valid = 1'b0;
      cyc("c14", 2'b00, 2'b11, 1'b1);
      cyc("c15", 2'b00, 2'b11, 1'b1);
      cyc("c16", 2'b11, 2'b00, 1'b1);
      cyc("c17", 2'b00, 2'b00, 1'b1);
      cyc("c18", 2'b00, 2'b00, 1'b1);
      cyc("c19", 2'b10, 2'b10, 1'b1);
      cyc("c20", 2'b01, 2'b11, 1'b1);
      cyc("c21", 2'b00, 2'b11, 1'b1);
      cyc("c22", 2'b10, 2'b01, 1'b1);
      cyc("c23", 2'b00, 2'b01, 1'b1);
      cyc("c24", 2'b01, 2'b00, 1'b1);
      cyc("c25", 2'b10, 2'b10, 1'b1);

      // ch0 <- 0, then ch0 <- 1
      cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd0;
      cyc("c26", 2'b00, 2'b10, 1'b0);
      cfg_valid = 1'b0;
      cyc("c27", 2'b01, 2'b11, 1'b1);
      cyc("c28", 2'b11, 2'b00, 1'b1);
      cfg_valid = 1'b1; cfg_div = 8'd1;
      cyc("c29", 2'b00, 2'b00, 1'b0);
      cfg_valid = 1'b0;
      cyc("c30", 2'b01, 2'b01, 1'b1);
      cyc("c31", 2'b11, 2'b10, 1'b1);
      cyc("c32", 2'b01, 2'b11, 1'b1);

      // ch0 <- 4, then ch0 <- 2 on the edge where count0 == 3
      cfg_valid = 1'b1; cfg_div = 8'd4;
      cyc("c33", 2'b00, 2'b11, 1'b0);
      cfg_valid = 1'b0;
      cyc("c34", 2'b10, 2'b01, 1'b1);
      cyc("c35", 2'b00, 2'b01, 1'b1);
      cyc("c36", 2'b00, 2'b01, 1'b1);
      cfg_valid = 1'b1; cfg_div = 8'd2;
      cyc("c37", 2'b10, 2'b11, 1'b0);
      cfg_valid = 1'b0;
      cyc("c38", 2'b00, 2'b11, 1'b1);
      cyc("c39", 2'b01, 2'b10, 1'b1);
      cyc("c40", 2'b10, 2'b00, 1'b1);
      cyc("c41", 2'b01, 2'b01, 1'b1);

      // ch0 <- 4, pause five cycles with count0 == 2
      cfg_valid = 1'b1; cfg_div = 8'd4;
      cyc("c42", 2'b00, 2'b01, 1'b0);
      cfg_valid = 1'b0;
      cyc("c43", 2'b10, 2'b11, 1'b1);
      cyc("c44", 2'b00, 2'b11, 1'b1);
      enable = 1'b0;
      for (int n = 45; n <= 49; n++) begin
         cyc($sformatf("hold%0d", n), 2'b00, 2'b11, 1'b1);
      end
      enable = 1'b1;
      cyc("c50", 2'b00, 2'b11, 1'b1);
      cyc("c51", 2'b11, 2'b00, 1'b1);
      cyc("c52", 2'b00, 2'b00, 1'b1);

      // Reset on the edge of an otherwise-accepted ch0 <- 7 update
      reset = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd7;
      cyc("rst2", 2'b00, 2'b00, 1'b0);
      chk("rst2_e_err", {7'd0, e_err}, 8'd0);
      reset = 1'b0; cfg_valid = 1'b0;
      cyc("r1", 2'b00, 2'b00, 1'b1);
      cyc("r2", 2'b00, 2'b00, 1'b1);
      cyc("r3", 2'b00, 2'b00, 1'b1);
      cyc("r4", 2'b11, 2'b11, 1'b1);
      chk("r4_err", {7'd0, cfg_err}, 8'd0);

`ifdef CLK_EN_GEN_SYNC_CLR_EN
      // Misalign ch1, then sync_clr coinciding with ch0 <- 2
      cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3;
      cyc("s5", 2'b00, 2'b11, 1'b0);
      cfg_valid = 1'b0;
      cyc("s6", 2'b00, 2'b11, 1'b1);
      sync_clr = 1'b1; cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd2;
      cyc("s7", 2'b00, 2'b00, 1'b0);
      sync_clr = 1'b0; cfg_valid = 1'b0;
      cyc("s8", 2'b00, 2'b00, 1'b1);
      cyc("s9", 2'b01, 2'b01, 1'b1);
      cyc("s10", 2'b10, 2'b11, 1'b1);
      cyc("s11", 2'b01, 2'b10, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Multi-channel, fully synchronous clock-enable generator. Successor to the flip-flop-chain clock divider.
- Produces single-cycle tick enables and 50% square outputs at runtime-programmable divide ratios.
- Logic stays on the single 100 MHz clock domain, so there are no derived clocks.
- Feeds display-scan, debounce and blink logic in the segment-display datapath.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 24, width of the divisor and of each channel counter.
- DEFAULT_DIV, 100000, divisor loaded into every channel on reset. Must fit in DIV_W.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global run. While low, all channels freeze.
- cfg_valid  in  1  divisor-update request.
- cfg_ready  out  1  update can be accepted this cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel index.
- cfg_div  in  DIV_W  new divisor N.
- cfg_err  out  1  sticky flag: an update addressed a channel index >= NUM_CH.
- tick  out  NUM_CH  one-cycle enable pulse per channel.
- square  out  NUM_CH  toggles on each tick of the channel; period 2N.

Behaviour:
- Reset (sampled on the clock edge): all counters = 0, div_reg[i] = DEFAULT_DIV, tick = 0, square = 0, cfg_ready = 0, cfg_err = 0.
- First cycle after reset deasserts: cfg_ready = 1.
- Effective divisor: Neff = (div_reg == 0) ? 1 : div_reg. Setting 0 or 1 gives a tick every enabled cycle.
- Per channel, on each edge with enable = 1:
  - If count == Neff-1: count <= 0, tick <= 1, square <= ~square.
  - Otherwise: count <= count+1, tick <= 0.
- Resulting timing: tick is registered and high for exactly 1 cycle every Neff enabled cycles. Period, counted from reset release with enable held high, is Neff cycles. The first tick is high in cycle Neff after release.
- enable = 0: counts hold, tick <= 0, square holds. Resuming continues from the held count; there is no phase reset.
- Handshake: an update is accepted on an edge where cfg_valid & cfg_ready.
  - cfg_ready <= 0 for the following cycle, then returns to 1. Maximum rate is one update per 2 cycles.
  - cfg_valid may stay high across a not-ready cycle. The payload must be held stable until accepted.
- Accepted update to a valid channel: div_reg <= cfg_div, count <= 0, tick <= 0, square unchanged.
  - The first new tick is high Neff(new) enabled cycles after the accepting edge.
  - The update applies even if enable = 0.
- Accepted update with cfg_ch >= NUM_CH: no channel changes and cfg_err <= 1. cfg_err is cleared only by reset.
- Update and terminal count on the same edge for the same channel: the update wins. No tick, no square toggle.
- Other channels are unaffected by an update.
- Reset asserted mid-count or mid-handshake: everything returns to reset values on that edge. An in-flight update is dropped.
- Counter arithmetic is DIV_W bits unsigned. Wrap occurs only via the terminal compare, never by overflow.

Optional Feature:
- Macro: CLK_EN_GEN_SYNC_CLR_EN.
- Defined: adds input port sync_clr (1 bit). When sync_clr = 1 on an edge, all counts <= 0, tick <= 0 and square <= 0, regardless of enable. This phase-aligns all channels.
  - If sync_clr and an update coincide, sync_clr wins for count, tick and square, and the update still writes div_reg.
- Undefined: the port is absent and behaviour is as above.

Decomposition:
- Package clk_en_pkg holds:
  - DIV_W_DEFAULT and NUM_CH_DEFAULT constants.
  - typedef div_t (logic [DIV_W-1:0]).
  - Function eff_div() implementing the 0→1 mapping.
- Sub-module clk_en_channel: one counter, div_reg, tick and square, with a per-channel load strobe. It is instantiated NUM_CH times in a generate loop.
- The top level holds the handshake, cfg_ch decode and cfg_err.

Test Plan (NUM_CH=2, DIV_W=8, DEFAULT_DIV=4):
- Reset release with enable=1: tick[0] high in cycles 4, 8, 12, and square[0] toggles at each. Both channels run in lockstep.
- Accept cfg_ch=1, cfg_div=3 at edge E: cfg_ready is low in cycle E+1. tick[1] is next high in cycle E+3, then every 3 cycles. Channel 0 is undisturbed.
- cfg_div=0 and then cfg_div=1 on ch0: tick[0] is high every cycle and square[0] toggles every cycle.
- Update to ch0 on the edge where count0==3: no tick in the next cycle and square[0] is unchanged. The next tick comes Neff(new) cycles later.
- enable low for 5 cycles at count=2: tick stays 0 and count holds. The next tick arrives 2 enabled cycles after resume.
- cfg_ch=3 accepted: cfg_err=1 and stays 1 until reset, with both channels unaffected. Also check reset asserted mid-handshake and the CLK_EN_GEN_SYNC_CLR_EN alignment.
